// File: rtl/rv_wb_biu_pkg.sv
// Shared definitions for the RV Wishbone bus interface unit: FSM state type
// and the default bus timeout.
package rv_wb_biu_pkg;

    localparam int unsigned RV_BIU_TIMEOUT_DEFAULT = 64;
    localparam int unsigned RV_BIU_CNT_W           = 16;

    typedef enum logic [1:0] {
        BIU_IDLE = 2'd0,
        BIU_BUSY = 2'd1,
        BIU_DONE = 2'd2
    } biu_state_t;

endpackage

// File: rtl/rv_biu_timer.sv
// Bus-access watchdog: counts cycles while enabled and flags the last
// allowed cycle before the access must be abandoned.
module rv_biu_timer
    import rv_wb_biu_pkg::*;
#(
    parameter int unsigned LIMIT = RV_BIU_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [RV_BIU_CNT_W-1:0] LAST = RV_BIU_CNT_W'(LIMIT - 1);

    logic [RV_BIU_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + RV_BIU_CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/rv_wb_biu.sv
// Core-to-Wishbone-classic bus interface unit: one outstanding access,
// registered master signals, error/timeout reporting with a done pulse.
module rv_wb_biu
    import rv_wb_biu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = RV_BIU_TIMEOUT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_adr,
    input  logic [31:0] i_req_dat,
    input  logic        i_req_we,
    input  logic [3:0]  i_req_sel,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rsp_dat,
    output logic        o_bus_err,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err
);

    biu_state_t state;
    biu_state_t state_next;
    logic       start;
    logic       finish;
    logic       capture;
    logic       set_err;
    logic       err_flag;
    logic       expired;

    rv_biu_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .clear   (start),
        .enable  (state == BIU_BUSY),
        .expired (expired)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= BIU_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // err is checked before ack so a simultaneous pair reports an error
    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        capture    = 1'b0;
        set_err    = 1'b0;
        case (state)
            BIU_IDLE: begin
                if (i_req_valid) begin
                    start      = 1'b1;
                    state_next = BIU_BUSY;
                end
            end
            BIU_BUSY: begin
                if (i_wb_err) begin
                    finish     = 1'b1;
                    set_err    = 1'b1;
                    state_next = BIU_DONE;
                end else if (i_wb_ack) begin
                    finish     = 1'b1;
                    capture    = !o_wb_we;
                    state_next = BIU_DONE;
                end else if (expired) begin
                    finish     = 1'b1;
                    set_err    = 1'b1;
                    state_next = BIU_DONE;
                end
            end
            BIU_DONE: begin
                state_next = BIU_IDLE;
            end
            default: begin
                state_next = BIU_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_wb_adr  <= '0;
            o_wb_dat  <= '0;
            o_wb_sel  <= '0;
            o_wb_we   <= 1'b0;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_rsp_dat <= '0;
            err_flag  <= 1'b0;
        end else begin
            if (start) begin
                o_wb_adr <= i_req_adr;
                o_wb_dat <= i_req_dat;
                o_wb_sel <= i_req_sel;
                o_wb_we  <= i_req_we;
                o_wb_cyc <= 1'b1;
                o_wb_stb <= 1'b1;
            end
            if (finish) begin
                o_wb_cyc <= 1'b0;
                o_wb_stb <= 1'b0;
            end
            if (capture) begin
                o_rsp_dat <= i_wb_dat;
            end
            if (set_err) begin
                err_flag <= 1'b1;
            end else if (state == BIU_DONE) begin
                err_flag <= 1'b0;
            end
        end
    end

    assign o_stall   = ((state == BIU_IDLE) && i_req_valid) || (state == BIU_BUSY);
    assign o_done    = (state == BIU_DONE);
    assign o_bus_err = (state == BIU_DONE) && err_flag;

endmodule

// File: tb/tb_rv_wb_biu.sv
// Directed bench for rv_wb_biu: reset, zero-wait read, waited write, timeout,
// ack at the limit, ack/err collision, reset mid-access, back-to-back reads.
module tb_rv_wb_biu;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic        req_we;
    logic [3:0]  req_sel;
    logic        stall;
    logic        done;
    logic [31:0] rsp_dat;
    logic        bus_err;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic [31:0] wb_dat_i;
    logic        wb_ack;
    logic        wb_err;

    int checks = 0;
    int errors = 0;

    rv_wb_biu #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_req_valid (req_valid),
        .i_req_adr   (req_adr),
        .i_req_dat   (req_dat),
        .i_req_we    (req_we),
        .i_req_sel   (req_sel),
        .o_stall     (stall),
        .o_done      (done),
        .o_rsp_dat   (rsp_dat),
        .o_bus_err   (bus_err),
        .o_wb_adr    (wb_adr),
        .o_wb_dat    (wb_dat_o),
        .o_wb_sel    (wb_sel),
        .o_wb_we     (wb_we),
        .o_wb_cyc    (wb_cyc),
        .o_wb_stb    (wb_stb),
        .i_wb_dat    (wb_dat_i),
        .i_wb_ack    (wb_ack),
        .i_wb_err    (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] adr, input logic [31:0] dat,
                           input logic we, input logic [3:0] sel);
        req_valid = 1'b1;
        req_adr   = adr;
        req_dat   = dat;
        req_we    = we;
        req_sel   = sel;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; req_adr = '0; req_dat = '0;
        req_we = 1'b0; req_sel = '0; wb_dat_i = '0; wb_ack = 1'b0; wb_err = 1'b0;
        tick(); tick();
        checks++;
        if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin
            errors++; $display("FAIL reset_ctl got %b exp 000", {wb_cyc, wb_stb, wb_we});
        end
        checks++;
        if ({wb_adr, wb_dat_o, wb_sel} !== 68'h0) begin
            errors++; $display("FAIL reset_bus got %h exp 0", {wb_adr, wb_dat_o, wb_sel});
        end
        checks++;
        if ({rsp_dat, done, bus_err, stall} !== 35'h0) begin
            errors++; $display("FAIL reset_out got %h exp 0", {rsp_dat, done, bus_err, stall});
        end
        req_valid = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL reset_stall_req got %b exp 1", stall);
        end
        req_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_read_zero_wait();
        request(32'h2000_0010, 32'h0, 1'b0, 4'hF);
        #1;
        checks++;
        if ({stall, wb_cyc, done} !== 3'b100) begin
            errors++; $display("FAIL rd0_n got %b exp 100", {stall, wb_cyc, done});
        end
        tick();
        req_valid = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({wb_cyc, wb_stb, wb_we, stall, done} !== 5'b11010 || wb_adr !== 32'h2000_0010) begin
            errors++; $display("FAIL rd0_n1 got %b adr %h exp 11010 adr 20000010",
                               {wb_cyc, wb_stb, wb_we, stall, done}, wb_adr);
        end
        tick();
        wb_ack = 1'b0; wb_dat_i = 32'h0;
        #1;
        checks++;
        if ({wb_cyc, done, bus_err, stall} !== 4'b0100 || rsp_dat !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rd0_n2 got %b rsp %h exp 0100 rsp deadbeef",
                               {wb_cyc, done, bus_err, stall}, rsp_dat);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL rd0_n3 done got %b exp 0", done);
        end
    endtask

    task automatic test_write_wait();
        int stall_cnt;
        stall_cnt = 0;
        request(32'h2000_0004, 32'h1234_5678, 1'b1, 4'b0011);
        #1;
        if (stall === 1'b1) stall_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick();
            request(32'hFFFF_FFFF, 32'h0, 1'b0, 4'hF);
            req_valid = 1'b0;
            wb_ack = (i == 3);
            #1;
            if (stall === 1'b1) stall_cnt++;
            checks++;
            if (wb_adr !== 32'h2000_0004 || wb_dat_o !== 32'h1234_5678 || wb_sel !== 4'b0011 ||
                {wb_we, wb_cyc, wb_stb} !== 3'b111) begin
                errors++; $display("FAIL wr_stable[%0d] got adr %h dat %h sel %b ctl %b exp 20000004 12345678 0011 111",
                                   i, wb_adr, wb_dat_o, wb_sel, {wb_we, wb_cyc, wb_stb});
            end
        end
        tick();
        wb_ack = 1'b0;
        #1;
        if (stall === 1'b1) stall_cnt++;
        checks++;
        if ({done, bus_err, wb_cyc} !== 3'b100 || rsp_dat !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_done got %b rsp %h exp 100 rsp deadbeef",
                               {done, bus_err, wb_cyc}, rsp_dat);
        end
        checks++;
        if (stall_cnt != 5) begin
            errors++; $display("FAIL wr_stall_cycles got %0d exp 5", stall_cnt);
        end
        tick();
    endtask

    task automatic test_timeout();
        request(32'h0000_0100, 32'h0, 1'b0, 4'hF);
        for (int i = 0; i < 8; i++) begin
            tick();
            req_valid = 1'b0;
            #1;
            checks++;
            if ({wb_cyc, done} !== 2'b10) begin
                errors++; $display("FAIL to_busy[%0d] got %b exp 10", i, {wb_cyc, done});
            end
        end
        tick();
        checks++;
        if ({wb_cyc, wb_stb, done, bus_err} !== 4'b0011 || rsp_dat !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL to_done got %b rsp %h exp 0011 rsp deadbeef",
                               {wb_cyc, wb_stb, done, bus_err}, rsp_dat);
        end
        wb_ack = 1'b1; wb_err = 1'b1;
        tick();
        checks++;
        if ({wb_cyc, done, bus_err} !== 3'b000) begin
            errors++; $display("FAIL to_idle got %b exp 000", {wb_cyc, done, bus_err});
        end
        tick();
        wb_ack = 1'b0; wb_err = 1'b0;
        #1;
        checks++;
        if ({wb_cyc, done, bus_err} !== 3'b000 || rsp_dat !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL to_ignore got %b rsp %h exp 000 rsp deadbeef",
                               {wb_cyc, done, bus_err}, rsp_dat);
        end
    endtask

    task automatic test_ack_at_limit();
        request(32'h0000_0200, 32'h0, 1'b0, 4'hF);
        for (int i = 0; i < 8; i++) begin
            tick();
            req_valid = 1'b0;
            wb_ack = (i == 7);
            wb_dat_i = 32'hCAFE_F00D;
        end
        tick();
        wb_ack = 1'b0;
        #1;
        checks++;
        if ({done, bus_err} !== 2'b10 || rsp_dat !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL limit_ack got %b rsp %h exp 10 rsp cafef00d",
                               {done, bus_err}, rsp_dat);
        end
        tick();
    endtask

    task automatic test_ack_err();
        request(32'h0000_0300, 32'h0, 1'b0, 4'hF);
        tick();
        req_valid = 1'b0; wb_ack = 1'b1; wb_err = 1'b1; wb_dat_i = 32'h5555_5555;
        tick();
        wb_ack = 1'b0; wb_err = 1'b0;
        #1;
        checks++;
        if ({done, bus_err, wb_cyc} !== 3'b110 || rsp_dat !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL ackerr got %b rsp %h exp 110 rsp cafef00d",
                               {done, bus_err, wb_cyc}, rsp_dat);
        end
        tick();
        checks++;
        if ({done, bus_err} !== 2'b00) begin
            errors++; $display("FAIL ackerr_clear got %b exp 00", {done, bus_err});
        end
    endtask

    task automatic test_reset_busy();
        request(32'h2000_0020, 32'hA5A5_A5A5, 1'b1, 4'b1010);
        tick();
        req_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({wb_cyc, wb_stb, stall} !== 3'b111) begin
            errors++; $display("FAIL rstb_pre got %b exp 111", {wb_cyc, wb_stb, stall});
        end
        tick();
        reset_n = 1'b1;
        #1;
        checks++;
        if ({wb_cyc, wb_stb, wb_we, done, bus_err, stall} !== 6'b0 ||
            {wb_adr, wb_dat_o, wb_sel, rsp_dat} !== 100'h0) begin
            errors++; $display("FAIL rstb_post got %b bus %h exp 0",
                               {wb_cyc, wb_stb, wb_we, done, bus_err, stall},
                               {wb_adr, wb_dat_o, wb_sel, rsp_dat});
        end
        tick();
        checks++;
        if ({done, wb_cyc} !== 2'b00) begin
            errors++; $display("FAIL rstb_nodone got %b exp 00", {done, wb_cyc});
        end
    endtask

    task automatic test_back_to_back();
        request(32'h0000_3000, 32'h0, 1'b0, 4'hF);
        tick();
        wb_ack = 1'b1; wb_dat_i = 32'h1;
        #1;
        checks++;
        if ({wb_cyc, stall} !== 2'b11) begin
            errors++; $display("FAIL b2b_busy1 got %b exp 11", {wb_cyc, stall});
        end
        tick();
        wb_ack = 1'b0;
        #1;
        checks++;
        if ({done, stall, wb_cyc} !== 3'b100 || rsp_dat !== 32'h1) begin
            errors++; $display("FAIL b2b_done1 got %b rsp %h exp 100 rsp 1",
                               {done, stall, wb_cyc}, rsp_dat);
        end
        tick();
        checks++;
        if ({done, stall, wb_cyc} !== 3'b010) begin
            errors++; $display("FAIL b2b_idle got %b exp 010", {done, stall, wb_cyc});
        end
        tick();
        wb_ack = 1'b1; wb_dat_i = 32'h2;
        #1;
        checks++;
        if ({wb_cyc, stall} !== 2'b11) begin
            errors++; $display("FAIL b2b_busy2 got %b exp 11", {wb_cyc, stall});
        end
        tick();
        wb_ack = 1'b0; req_valid = 1'b0;
        #1;
        checks++;
        if ({done, bus_err} !== 2'b10 || rsp_dat !== 32'h2) begin
            errors++; $display("FAIL b2b_done2 got %b rsp %h exp 10 rsp 2", {done, bus_err}, rsp_dat);
        end
        tick();
        checks++;
        if ({done, stall, wb_cyc} !== 3'b000) begin
            errors++; $display("FAIL b2b_end got %b exp 000", {done, stall, wb_cyc});
        end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_timeout();
        test_ack_at_limit();
        test_ack_err();
        test_reset_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_wb_biu.md
RV_WB_BIU -- requirements
Module: rv_wb_biu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64; meaning: maximum BUSY cycles waiting for ack/err before the access is aborted (legal range 2..65535).
REQ-002 i_clk  in  1  core clock; all state changes on its rising edge.
REQ-003 i_reset_n  in  1  one clock; reset is synchronous and active-low.
REQ-004 i_req_valid  in  1  core load/store request, driven from the core's stb|cyc.
REQ-005 i_req_adr  in  32  byte address of the core request.
REQ-006 i_req_dat  in  32  core write data.
REQ-007 i_req_we  in  1  1 = write, 0 = read.
REQ-008 i_req_sel  in  4  byte-lane enables.
REQ-009 o_stall  out  1  holds the core pipeline while an access is outstanding.
REQ-010 o_done  out  1  one-cycle completion pulse.
REQ-011 o_rsp_dat  out  32  read data of the last completed read.
REQ-012 o_bus_err  out  1  one-cycle pulse, coincident with o_done, on bus error or timeout.
REQ-013 o_wb_adr / o_wb_dat / o_wb_sel / o_wb_we / o_wb_cyc / o_wb_stb  out  32/32/4/1/1/1  registered Wishbone classic master signals.
REQ-014 i_wb_dat / i_wb_ack / i_wb_err  in  32/1/1  Wishbone slave response.

Function
REQ-015 FSM states: IDLE, BUSY, DONE.
REQ-016 IDLE with i_req_valid=1: latch adr/dat/we/sel into o_wb_*, set cyc=stb=1, clear timeout counter, go to BUSY on the next edge.
REQ-017 BUSY with i_wb_ack=1: drop cyc/stb; if read, capture i_wb_dat into o_rsp_dat; go to DONE.
REQ-018 BUSY with i_wb_err=1: drop cyc/stb; go to DONE with the error flag set; o_rsp_dat unchanged.
REQ-019 BUSY with ack and err both high in one cycle: err wins.
REQ-020 BUSY with no response: counter increments once per cycle; when it reaches TIMEOUT_CYCLES-1 and no ack/err is present, drop cyc/stb and go to DONE with the error flag set.
REQ-021 Ack arriving in the same cycle the counter reaches its limit counts as a normal completion.
REQ-022 DONE: o_done=1 for exactly one cycle, o_bus_err=error flag; go to IDLE unconditionally; error flag clears on the next edge.
REQ-023 o_stall = (IDLE and i_req_valid) or BUSY; combinational; 0 in DONE so the core advances that cycle.
REQ-024 A new request cannot start in DONE; a request still asserted on return to IDLE starts a new access.
REQ-025 Writes never modify o_rsp_dat.
REQ-026 i_wb_ack and i_wb_err are ignored in IDLE and DONE.
REQ-027 Zero-wait-state slave (ack in the first cycle of cyc/stb): request cycle N, cyc/stb cycles N+1, o_done cycle N+2, o_stall high cycles N..N+1.
REQ-028 o_wb_adr, o_wb_dat, o_wb_sel and o_wb_we stay stable throughout BUSY regardless of changes on the i_req_* inputs.

Reset
REQ-029 On i_reset_n=0 at an edge: state=IDLE; o_wb_cyc=o_wb_stb=o_wb_we=0; o_wb_adr=o_wb_dat=0; o_wb_sel=0; o_rsp_dat=0; counter=0; error flag=0.
REQ-030 Reset asserted during BUSY drops cyc/stb at that edge; no o_done is produced for the aborted access.
REQ-031 o_stall is 0 while in reset only if i_req_valid is 0.

Structure
REQ-032 FSM state typedef and the default TIMEOUT_CYCLES value live in the shared rv package/defines alongside the existing core defines.
REQ-033 The timeout counter is a sub-module, rv_biu_timer, with clear, enable and expired ports; all other logic stays in rv_wb_biu.

Verification
REQ-034 Read, ack on the first cycle, i_wb_dat=32'hDEADBEEF, adr=32'h2000_0010 -> cyc/stb for one cycle, o_done at N+2, o_rsp_dat=32'hDEADBEEF, o_bus_err=0.
REQ-035 Write, adr=32'h2000_0004, sel=4'b0011, ack after 3 wait cycles -> o_wb_* stable for 4 cycles, o_stall high for 5 cycles, o_rsp_dat unchanged.
REQ-036 Read with no response, TIMEOUT_CYCLES=8 -> cyc drops after 8 BUSY cycles, o_done=o_bus_err=1 for one cycle, o_rsp_dat unchanged.
REQ-037 ack and err both high in one cycle -> o_bus_err=1, o_rsp_dat unchanged.
REQ-038 i_reset_n=0 during the second BUSY cycle -> cyc/stb=0 on the next edge, no o_done, all outputs at reset values.
REQ-039 Back-to-back requests (i_req_valid held high, two reads returning 32'h1 then 32'h2) -> two accesses separated by one DONE cycle, with o_rsp_dat values 32'h1 then 32'h2.
